// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX core between NUM_REQ byte requesters.
// Optional WAIT_ACK watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] ptr_after;
  logic             found;
  logic             grant;
  logic             timeout_hit;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    sel      = rr_ptr;
    scan_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end
  end

  // Gated by rst_n so no accept strobe can leak out while reset is held.
  assign grant     = rst_n && (state == IDLE) && !tx_busy && found;
  assign req_ready = grant ? (NUM_REQ'(1) << sel) : '0;
  assign ptr_after = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_err_q;
`endif

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (grant) state_next = START;
      START:     state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // tx_start and arb_busy are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      tx_data  <= '0;
      grant_id <= '0;
      tx_start <= 1'b0;
      arb_busy <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= (state_next == START);
      arb_busy <= (state_next != IDLE);
      if (grant) begin
        tx_data  <= req_data[int'(sel)*DATA_W +: DATA_W];
        grant_id <= sel;
      end
      if ((state == WAIT_DONE && !tx_busy) || timeout_hit) begin
        rr_ptr <= ptr_after;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Counter restarts on every entry to WAIT_ACK and counts idle tx_busy cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_hit;
      if (state_next == WAIT_ACK && state != WAIT_ACK) begin
        wait_cnt <= '0;
      end else if (state == WAIT_ACK && !tx_busy) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (grant_id, tx_data) pairs are
// queued with the stimulus and popped whenever the DUT pulses tx_start.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  logic        model_en;
  logic        man_busy;
  logic        model_busy = 1'b0;
  int          pend = 0;
  int          hold = 0;
  int          busy_len;

  logic        oneshot;
  logic [3:0]  hs_q = '0;
  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign tx_busy = model_en ? model_busy : man_busy;

  // TX core model: busy rises 2 cycles after tx_start and lasts busy_len cycles.
  always @(negedge clk) begin
    if (!model_en || !rst_n) begin
      model_busy = 1'b0;
      pend       = 0;
      hold       = 0;
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        model_busy = 1'b1;
        hold       = busy_len;
      end
    end else if (model_busy) begin
      hold = hold - 1;
      if (hold == 0) model_busy = 1'b0;
    end else if (tx_start === 1'b1) begin
      pend = 2;
    end
  end

  always @(posedge clk) hs_q <= req_ready & req_valid;

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (oneshot) req_valid = req_valid & ~hs_q;
    @(negedge clk);
    #1;
    if (tx_start === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: grant_id=%0d tx_data=%h, required no transfer", grant_id, tx_data);
      end else begin
        e = sb_q.pop_front();
        if (grant_id !== e.id || tx_data !== e.data) begin
          bad++;
          $display("[TB] FAIL sb_transfer: grant_id=%0d tx_data=%h, required grant_id=%0d tx_data=%h",
                   grant_id, tx_data, e.id, e.data);
        end
      end
    end
  endtask

  task automatic run_sb(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (arb_busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    model_en  = 1'b1;
    man_busy  = 1'b0;
    busy_len  = 10;
    oneshot   = 1'b0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_req_ready: got %b, required 0000", req_ready); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_start: got %b, required 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data: got %h, required 00", tx_data); end
    total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_arb_busy: got %b, required 0", arb_busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_grant_id: got %0d, required 0", grant_id); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout_err: got %b, required 0", timeout_err); end
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL reset_first_ready: got %b, required 0001", req_ready); end
    sb_q.push_back(exp_t'{2'd0, 8'h10});
    run_sb(5);
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL reset_first_grant: pending=%0d, required 0", sb_q.size()); end
    req_valid = '0;
    wait_idle(60);
  endtask

  task automatic test_single_transfer();
    int rdy_cnt = 0, rdy_cyc = -1, st_cyc = -1, busy_cnt = 0, other = 0;
    do_reset();
    model_en  = 1'b1;
    busy_len  = 10;
    oneshot   = 1'b1;
    req_data  = 32'h0;
    req_data[2*DATA_W +: DATA_W] = 8'hA5;
    req_valid = 4'b0100;
    sb_q.push_back(exp_t'{2'd2, 8'hA5});
    #1;
    for (int c = 0; c < 40; c++) begin
      if (req_ready === 4'b0100) begin rdy_cnt++; rdy_cyc = c; end
      else if (req_ready !== 4'b0000) other++;
      if (tx_start === 1'b1) st_cyc = c;
      if (arb_busy === 1'b1) busy_cnt++;
      step();
    end
    total++; if (rdy_cnt != 1 || other != 0) begin bad++; $display("[TB] FAIL single_ready: cycles=%0d stray=%0d, required 1 and 0", rdy_cnt, other); end
    total++; if (st_cyc != rdy_cyc + 1) begin bad++; $display("[TB] FAIL single_start_latency: start=%0d ready=%0d, required start=ready+1", st_cyc, rdy_cyc); end
    total++; if (busy_cnt != 13) begin bad++; $display("[TB] FAIL single_arb_busy: cycles=%0d, required 13", busy_cnt); end
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL single_sb: pending=%0d, required 0", sb_q.size()); end
    total++; if (tx_data !== 8'hA5 || grant_id !== 2'd2) begin bad++; $display("[TB] FAIL single_hold: tx_data=%h grant_id=%0d, required A5 and 2", tx_data, grant_id); end
  endtask

  task automatic test_round_robin();
    do_reset();
    model_en  = 1'b1;
    busy_len  = 4;
    oneshot   = 1'b0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    sb_q.push_back(exp_t'{2'd0, 8'h10});
    sb_q.push_back(exp_t'{2'd1, 8'h11});
    sb_q.push_back(exp_t'{2'd2, 8'h12});
    sb_q.push_back(exp_t'{2'd3, 8'h13});
    sb_q.push_back(exp_t'{2'd0, 8'h10});
    run_sb(200);
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL rr_order: pending=%0d, required 0", sb_q.size()); end
    req_valid = '0;
    wait_idle(60);
  endtask

  task automatic test_wrap_skip();
    do_reset();
    model_en  = 1'b1;
    busy_len  = 4;
    oneshot   = 1'b1;
    req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    req_valid = 4'b1000;
    sb_q.push_back(exp_t'{2'd3, 8'h33});
    run_sb(20);
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL wrap_first: pending=%0d, required 0", sb_q.size()); end
    wait_idle(60);
    oneshot   = 1'b0;
    req_valid = 4'b1001;
    sb_q.push_back(exp_t'{2'd0, 8'h30});
    sb_q.push_back(exp_t'{2'd3, 8'h33});
    sb_q.push_back(exp_t'{2'd0, 8'h30});
    run_sb(200);
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL wrap_order: pending=%0d, required 0", sb_q.size()); end
    req_valid = '0;
    wait_idle(60);
  endtask

  task automatic test_blocked_tx();
    model_en = 1'b0;
    man_busy = 1'b1;
    do_reset();
    oneshot   = 1'b1;
    req_data  = 32'h0;
    req_data[0 +: DATA_W] = 8'h5A;
    req_valid = 4'b0001;
    sb_q.push_back(exp_t'{2'd0, 8'h5A});
    #1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (req_ready !== 4'b0000 || arb_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL blocked_no_grant: req_ready=%b arb_busy=%b, required 0000 and 0", req_ready, arb_busy);
      end
      step();
    end
    man_busy = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL blocked_release: req_ready=%b, required 0001", req_ready); end
    model_en = 1'b1;
    busy_len = 4;
    run_sb(1);
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL blocked_start: pending=%0d, required 0", sb_q.size()); end
    wait_idle(60);
  endtask

  task automatic test_timeout();
    int k = 0;
    int pulses = 0;
    model_en = 1'b0;
    man_busy = 1'b0;
    do_reset();
    oneshot   = 1'b1;
    req_data  = {8'h00, 8'h00, 8'h21, 8'h77};
    req_valid = 4'b0001;
    sb_q.push_back(exp_t'{2'd0, 8'h77});
    run_sb(5);
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL timeout_first: pending=%0d, required 0", sb_q.size()); end
`ifdef UART_ARB_TIMEOUT_EN
    while (timeout_err !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    total++; if (k != 9) begin bad++; $display("[TB] FAIL timeout_delay: cycles=%0d, required 9", k); end
    total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_idle: arb_busy=%b, required 0", arb_busy); end
    for (int c = 0; c < 12; c++) begin
      step();
      if (timeout_err === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("[TB] FAIL timeout_single_pulse: extra=%0d, required 0", pulses); end
    model_en  = 1'b1;
    busy_len  = 4;
    req_valid = 4'b0011;
    sb_q.push_back(exp_t'{2'd1, 8'h21});
    run_sb(10);
    total++; if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL timeout_next_grant: pending=%0d, required 0", sb_q.size()); end
    req_valid = '0;
    wait_idle(60);
`else
    for (int c = 0; c < 120; c++) begin
      step();
      if (timeout_err !== 1'b0) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("[TB] FAIL timeout_err_tied: pulses=%0d, required 0", pulses); end
    total++; if (arb_busy !== 1'b1) begin bad++; $display("[TB] FAIL timeout_wait_ack: arb_busy=%b, required 1", arb_busy); end
    k = 0;
    do_reset();
    total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_reset_abort: arb_busy=%b, required 0", arb_busy); end
`endif
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    model_en  = 1'b1;
    man_busy  = 1'b0;
    busy_len  = 10;
    oneshot   = 1'b0;
    test_reset();
    test_single_transfer();
    test_round_robin();
    test_wrap_skip();
    test_blocked_tx();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
